apb_mem_slave: RTL and testbench

Parametrised APB4 completer that fronts a word-addressed on-chip memory. It is the successor to the fixed 16-bit-address / 32-bit-data APB slave model: data width, address width, depth and wait states are configurable, byte strobes are honoured, and errors are signalled. It sits behind the AHB-to-APB bridge as the memory target that the AHB/APB memory environment drives and checks.

---
 rtl/apb_mem_pkg.sv | 20 ++
 rtl/apb_mem_array.sv | 34 +++
 rtl/apb_mem_slave.sv | 139 +++++++++++++
 tb/tb_apb_mem_slave.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/apb_mem_pkg.sv
// Shared types and sizing helpers for the APB4 memory completer.
// The state enum, response struct and lane/offset helpers are used by both the top and the memory array.
package apb_mem_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;

  typedef struct packed {
    logic ready;
    logic slverr;
  } apb_resp_t;

  function automatic int strb_w(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int addr_lsb(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/apb_mem_array.sv
// Byte-strobed single-port word memory: synchronous write, combinational read.
// Contents are not reset; the writer is responsible for only ever presenting in-range indices.
module apb_mem_array
  import apb_mem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 32,
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [strb_w(WIDTH)-1:0]  strb,
  input  logic [IDX_W-1:0]          idx,
  input  logic [WIDTH-1:0]          wdata,
  output logic [WIDTH-1:0]          rdata
);

  localparam int STRB_W = strb_w(WIDTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (strb[i]) begin
          mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/apb_mem_slave.sv
// APB4 completer over a word memory with configurable wait states, byte strobes and PSLVERR.
// Zero-wait when wait_cfg=0; define APB_MEM_PROT_EN to make the upper half secure-only (PPROT[1]=0).
module apb_mem_slave
  import apb_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter int MAX_WAIT   = 15
) (
  input  logic                           PCLK,
  input  logic                           PRESETn,
  input  logic                           PSEL,
  input  logic                           PENABLE,
  input  logic                           PWRITE,
  input  logic [ADDR_WIDTH-1:0]          PADDR,
  input  logic [DATA_WIDTH-1:0]          PWDATA,
  input  logic [DATA_WIDTH/8-1:0]        PSTRB,
  input  logic [2:0]                     PPROT,
  input  logic [$clog2(MAX_WAIT+1)-1:0]  wait_cfg,
  output logic                           PREADY,
  output logic [DATA_WIDTH-1:0]          PRDATA,
  output logic                           PSLVERR
);

  localparam int STRB_W   = strb_w(DATA_WIDTH);
  localparam int ADDR_LSB = addr_lsb(DATA_WIDTH);
  localparam int IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(MEM_DEPTH);

  apb_state_e             state_q, state_d, cur_state;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       widx_q, widx_d;
  logic                   write_q, write_d;
  logic                   err_q, err_d;
  logic [ADDR_WIDTH-1:0]  pidx;
  logic                   setup_err;
  apb_resp_t              resp;
  logic                   mem_we;
  logic [DATA_WIDTH-1:0]  mem_rdata;

  assign pidx = PADDR >> ADDR_LSB;

`ifdef APB_MEM_PROT_EN
  localparam logic [ADDR_WIDTH:0] HALF_LIM = (ADDR_WIDTH+1)'(MEM_DEPTH / 2);
  always_comb begin
    setup_err = ((PADDR & ADDR_WIDTH'(STRB_W - 1)) != '0) || ({1'b0, pidx} >= DEPTH_LIM);
    if (PPROT[1] && ({1'b0, pidx} >= HALF_LIM)) begin
      setup_err = 1'b1;
    end
  end
`else
  logic unused_pprot;
  assign unused_pprot = ^PPROT;
  always_comb begin
    setup_err = ((PADDR & ADDR_WIDTH'(STRB_W - 1)) != '0) || ({1'b0, pidx} >= DEPTH_LIM);
  end
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      widx_q  <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
      write_q <= write_d;
      err_q   <= err_d;
    end
  end

  // The setup phase is recognised from the bus itself, so a transfer issued
  // straight after PREADY gets its SETUP cycle with no idle gap.
  always_comb begin
    cur_state = IDLE;
    if (state_q == ACCESS) begin
      cur_state = ACCESS;
    end else if (PSEL && !PENABLE) begin
      cur_state = SETUP;
    end

    state_d = state_q;
    cnt_d   = cnt_q;
    widx_d  = widx_q;
    write_d = write_q;
    err_d   = err_q;
    case (cur_state)
      SETUP: begin
        state_d = ACCESS;
        widx_d  = IDX_W'(pidx);
        write_d = PWRITE;
        err_d   = setup_err;
        cnt_d   = (wait_cfg > CNT_W'(MAX_WAIT)) ? CNT_W'(MAX_WAIT) : wait_cfg;
      end
      ACCESS: begin
        if (!(PSEL && PENABLE)) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    resp   = '0;
    mem_we = 1'b0;
    if ((cur_state == ACCESS) && PSEL && PENABLE && (cnt_q == '0)) begin
      resp.ready  = 1'b1;
      resp.slverr = err_q;
      mem_we      = write_q && !err_q;
    end
    PREADY  = resp.ready;
    PSLVERR = resp.slverr;
    PRDATA  = (resp.ready && !write_q && !err_q) ? mem_rdata : '0;
  end

  apb_mem_array #(
    .DEPTH (MEM_DEPTH),
    .WIDTH (DATA_WIDTH),
    .IDX_W (IDX_W)
  ) u_mem (
    .clk   (PCLK),
    .we    (mem_we),
    .strb  (PSTRB),
    .idx   (widx_q),
    .wdata (PWDATA),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: directed APB scenarios plus randomized traffic checked
// against a word-array memory model and the wait-state/error rules.
module tb_apb_mem_slave;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        PSEL, PENABLE, PWRITE;
  logic [15:0] PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;
  logic [3:0]  wait_cfg;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model_mem [0:1023];

  apb_mem_slave dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PSTRB    (PSTRB),
    .PPROT    (PPROT),
    .wait_cfg (wait_cfg),
    .PREADY   (PREADY),
    .PRDATA   (PRDATA),
    .PSLVERR  (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic addr_is_err(input logic [15:0] a);
    return (a % 4 != 0) || ((a / 4) >= 1024);
  endfunction

  task automatic go_idle();
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PSTRB = '0;
  endtask

  // Runs one transfer; returns at the falling edge inside the PREADY cycle
  // so the caller can either go idle or start the next transfer back-to-back.
  task automatic xfer(input logic wr, input logic [15:0] a, input logic [31:0] wd,
                      input logic [3:0] st, input int wt,
                      output logic [31:0] rd, output logic err, output int cyc);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = wd; PSTRB = st;
    PPROT = 3'($urandom); wait_cfg = 4'(wt);
    @(negedge PCLK);
    check("setup_pready", PREADY, 0);
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    cyc = 0; rd = '0; err = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge PCLK);
      cyc++;
      if (PREADY === 1'b1) begin
        rd  = PRDATA;
        err = PSLVERR;
        break;
      end
      check("wait_prdata", PRDATA, 0);
      check("wait_pslverr", PSLVERR, 0);
    end
  endtask

  task automatic do_op(input logic wr, input logic [15:0] a, input logic [31:0] wd,
                       input logic [3:0] st, input int wt, output logic [31:0] rd);
    logic        exp_err, err;
    logic [31:0] exp_rd;
    int          cyc;
    exp_err = addr_is_err(a);
    exp_rd  = (!wr && !exp_err) ? model_mem[a / 4] : 32'h0;
    xfer(wr, a, wd, st, wt, rd, err, cyc);
    check("latency", cyc, wt + 1);
    check("pslverr", err, exp_err);
    check("prdata", rd, exp_rd);
    if (wr && !exp_err) begin
      for (int i = 0; i < 4; i++) begin
        if (st[i]) model_mem[a / 4][8*i +: 8] = wd[8*i +: 8];
      end
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [15:0] a;
    logic        err;
    int          cyc, sel;

    PRESETn = 1'b0; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0;
    PWDATA = '0; PSTRB = '0; PPROT = '0; wait_cfg = '0;
    repeat (3) @(negedge PCLK);
    check("rst_pready", PREADY, 0);
    check("rst_prdata", PRDATA, 0);
    check("rst_pslverr", PSLVERR, 0);
    PRESETn = 1'b1;

    for (int w = 0; w < 16; w++) begin
      do_op(1'b1, 16'(w * 4), $urandom, 4'hF, $urandom_range(0, 2), rd);
      go_idle();
    end

    do_op(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 0, rd); go_idle();
    do_op(1'b0, 16'h0010, 32'h0, 4'h0, 0, rd);        go_idle();
    check("read_deadbeef", rd, 32'hDEADBEEF);
    do_op(1'b0, 16'h0010, 32'h0, 4'h0, 3, rd);        go_idle();
    check("read_wait3", rd, 32'hDEADBEEF);
    do_op(1'b1, 16'h0010, 32'h11223344, 4'b0101, 1, rd); go_idle();
    do_op(1'b0, 16'h0010, 32'h0, 4'h0, 0, rd);        go_idle();
    check("strobe_merge", rd, 32'hDE22BE44);
    do_op(1'b1, 16'h0010, 32'hFFFFFFFF, 4'h0, 0, rd); go_idle();
    do_op(1'b0, 16'h0010, 32'h0, 4'h0, 15, rd);       go_idle();
    check("null_strobe_wait15", rd, 32'hDE22BE44);

    do_op(1'b1, 16'h1000, 32'hCAFEF00D, 4'hF, 0, rd); go_idle();
    do_op(1'b1, 16'h0012, 32'hCAFEF00D, 4'hF, 2, rd); go_idle();
    do_op(1'b0, 16'h0012, 32'h0, 4'h0, 0, rd);        go_idle();
    do_op(1'b0, 16'h0010, 32'h0, 4'h0, 0, rd);        go_idle();
    check("err_mem_unchanged", rd, 32'hDE22BE44);

    do_op(1'b1, 16'h0004, 32'hA5A55A5A, 4'hF, 0, rd);
    do_op(1'b0, 16'h0004, 32'h0, 4'h0, 0, rd);        go_idle();
    check("b2b_read", rd, 32'hA5A55A5A);

    // Abort: PSEL dropped during a wait state of a write.
    @(posedge PCLK); #1;
    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 16'h0008; PWDATA = 32'h0BAD0BAD;
    PSTRB = 4'hF; wait_cfg = 4'd3;
    @(posedge PCLK); #1; PENABLE = 1;
    @(negedge PCLK);
    check("abort_wait_pready", PREADY, 0);
    @(posedge PCLK); #1; PSEL = 0; PENABLE = 0;
    repeat (4) begin
      @(negedge PCLK);
      check("abort_pready", PREADY, 0);
      check("abort_pslverr", PSLVERR, 0);
    end
    do_op(1'b0, 16'h0008, 32'h0, 4'h0, 0, rd); go_idle();

    // Reset pulsed mid-ACCESS of a write.
    @(posedge PCLK); #1;
    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 16'h000C; PWDATA = 32'h5EC0FFEE;
    PSTRB = 4'hF; wait_cfg = 4'd5;
    @(posedge PCLK); #1; PENABLE = 1;
    repeat (2) @(negedge PCLK);
    #2 PRESETn = 1'b0;
    #1;
    check("midrst_pready", PREADY, 0);
    check("midrst_pslverr", PSLVERR, 0);
    check("midrst_prdata", PRDATA, 0);
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    repeat (8) begin
      @(negedge PCLK);
      check("postrst_pready", PREADY, 0);
      check("postrst_pslverr", PSLVERR, 0);
    end
    go_idle();
    do_op(1'b0, 16'h000C, 32'h0, 4'h0, 0, rd); go_idle();

    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = 16'($urandom_range(16'h1000, 16'hFFFF));
      else if (sel == 1) a = 16'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      else               a = 16'($urandom_range(0, 15) * 4);
      do_op(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), $urandom_range(0, 4), rd);
      if ($urandom_range(0, 2) != 0) go_idle();
    end
    go_idle();
    for (int w = 0; w < 16; w++) begin
      do_op(1'b0, 16'(w * 4), 32'h0, 4'h0, 0, rd);
    end
    go_idle();
    xfer(1'b0, 16'h0000, 32'h0, 4'h0, 0, rd, err, cyc);
    go_idle();
    @(negedge PCLK);
    check("final_idle_pready", PREADY, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
